para2ser_hs: RTL and testbench
==============================

# para2ser_hs

Parametrised parallel-to-serial converter with a valid/ready load handshake, one-word skid buffer and configurable bit order. It emits each accepted word as WIDTH serial symbols, one symbol per DIV clocks. Back-to-back words are sent with no gap. It sits in the QPSK transmit path between the frame builder and the symbol mapper, replacing the free-running fixed-40-bit serialiser.

## Interface
Parameters:
- WIDTH, 40, bits per word (≥2)
- DIV, 1000, clocks per symbol (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- para_i  in  WIDTH  word to serialise
- para_valid_i  in  1  para_i valid
- para_ready_o  out  1  block can accept a word; transfer when valid && ready at clk edge
- ser_o  out  1  serial data, registered
- ser_valid_o  out  1  high while ser_o carries a frame bit
- sym_stb_o  out  1  one-cycle pulse on the first cycle of every symbol
- frame_done_o  out  1  one-cycle pulse on the last cycle of a frame's last symbol

## Operation
- Storage:
  - Rotating shift register sh (WIDTH).
  - Holding register hold plus flag hold_full.
  - Symbol counter div_cnt, 0..DIV-1.
  - Bit counter bit_cnt, 0..WIDTH-1.
- FSM has two states:
  - IDLE: ser_o=0, ser_valid_o=0, div_cnt and bit_cnt held at 0.
  - SHIFT: a frame is being sent.
- para_ready_o = ~hold_full && ~rst (combinational).
- Accept in IDLE: word loads directly into sh, FSM → SHIFT, div_cnt=0, bit_cnt=0.
- Accept in SHIFT, not on the last frame cycle: word loads into hold and hold_full is set.
- Accept in SHIFT on the last frame cycle (bit_cnt=WIDTH-1, div_cnt=DIV-1) with hold empty: word bypasses hold and loads directly into sh.
- End of frame (bit_cnt=WIDTH-1 && div_cnt=DIV-1):
  - frame_done_o pulses.
  - If hold_full: hold → sh, hold_full clears, FSM stays in SHIFT, next frame starts on the next cycle.
  - Else if bypass accept: FSM stays in SHIFT.
  - Else: default FSM → IDLE (see Configuration).
- Symbol advance: at div_cnt=DIV-1, sh rotates one place (left if MSB_FIRST, else right) and bit_cnt increments, wrapping WIDTH-1→0.
- ser_o is registered from the current head bit of sh (sh[WIDTH-1] or sh[0]).
- Arithmetic:
  - div_cnt width = $clog2(DIV).
  - bit_cnt width = $clog2(WIDTH).
  - Compare against DIV-1 and WIDTH-1 at full counter width; no truncation.

## Timing
- Reset values: ser_o=0, ser_valid_o=0, sym_stb_o=0, frame_done_o=0, para_ready_o=0 while rst is high, 1 after release. Internal: hold_full=0, FSM=IDLE.
- Latency: an accept at edge t puts the first bit on ser_o, ser_valid_o=1 and sym_stb_o=1 at cycle t+1.
- Each bit is held exactly DIV cycles; a frame lasts WIDTH·DIV cycles.
- Back-to-back frames: zero idle cycles, ser_valid_o stays high.
- ser_valid_o falls in the cycle after frame_done_o when nothing is pending.
- rst mid-frame: all outputs and state clear immediately (asynchronous). The in-flight word and any held word are discarded; there is no partial-frame resume.
- para_i is sampled only at accept; later changes have no effect.

## Configuration
- PARA2SER_REPEAT_EN defined: at end of frame with nothing pending, sh (already rotated back to the original word) restarts the same word. FSM stays in SHIFT, frame_done_o still pulses every frame, and ser_valid_o stays high. This matches the legacy continuous-cycling behaviour. A new accept replaces the word at the next frame boundary.
- PARA2SER_REPEAT_EN undefined: the FSM returns to IDLE as described above.

## Structure
- Package para2ser_pkg holds:
  - FSM state typedef (ST_IDLE, ST_SHIFT).
  - A counter-width helper function.
- Sub-module sym_tick_gen (parameter DIV; ports clk, rst, en, div_cnt, sym_stb, sym_last) owns the symbol divider. The top holds the FSM, sh, hold and bit_cnt.

## Test plan
- Reset: hold rst 5 cycles, release → all outputs 0, para_ready_o=1 from the first cycle after release.
- WIDTH=8, DIV=4, MSB_FIRST=1, single accept of 8'hA5 → ser_o = 1,0,1,0,0,1,0,1, each held 4 cycles, starting the cycle after accept. frame_done_o pulses on cycle 32 after accept. Then IDLE with ser_o=0 and ser_valid_o=0.
- Back-to-back: para_valid_i held high with 8'hA5 then 8'h3C → second word accepted on the next cycle into hold, para_ready_o=0 until the frame boundary. ser_o continues with 0,0,1,1,1,1,0,0 and no gap.
- MSB_FIRST=0, 8'h01 → ser_o = 1 then seven 0s. sym_stb_o pulses 8 times, 4 cycles apart.
- rst asserted during bit 3 of 8'hA5 with 8'h3C held → outputs 0 immediately. After release the block is in IDLE and 8'h3C is never sent.
- With PARA2SER_REPEAT_EN, single accept 8'hF0 → pattern 11110000 repeats indefinitely. frame_done_o pulses every 32 cycles and ser_valid_o never drops.

Source files
------------

// File: rtl/para2ser_pkg.sv
// Shared types and helpers for the para2ser_hs parallel-to-serial converter.
// Holds the FSM state encoding and the counter-width helper.
package para2ser_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Width of a counter spanning 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/para2ser_sym_tick_gen.sv
// Symbol divider for para2ser_hs: counts 0..DIV-1 while enabled and flags
// the first and last cycle of each symbol. Held at zero while disabled.
module sym_tick_gen
   import para2ser_pkg::*;
#(
   parameter  int DIV = 1000,
   localparam int DW  = cnt_width(DIV)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [DW-1:0] div_cnt,
   output logic          sym_stb,
   output logic          sym_last
);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;

   always_comb begin
      div_cnt_d = '0;
      if (en) begin
         div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign div_cnt  = div_cnt_q;
   assign sym_stb  = en && (div_cnt_q == '0);
   assign sym_last = en && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/para2ser_hs.sv
// Parallel-to-serial converter with valid/ready load, one-word skid buffer
// and configurable bit order. Define PARA2SER_REPEAT_EN to re-send the last word forever.
module para2ser_hs
   import para2ser_pkg::*;
#(
   parameter int WIDTH     = 40,
   parameter int DIV       = 1000,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] para_i,
   input  logic             para_valid_i,
   output logic             para_ready_o,
   output logic             ser_o,
   output logic             ser_valid_o,
   output logic             sym_stb_o,
   output logic             frame_done_o
);

   localparam int             DW       = cnt_width(DIV);
   localparam int             BW       = cnt_width(WIDTH);
   localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             ser_q, ser_d;

   logic [DW-1:0]    div_cnt;
   logic             sym_stb;
   logic             sym_last;
   logic             accept;
   logic             frame_last;
   logic [WIDTH-1:0] sh_rot;

   sym_tick_gen #(.DIV(DIV)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .en       (state_q == ST_SHIFT),
      .div_cnt  (div_cnt),
      .sym_stb  (sym_stb),
      .sym_last (sym_last)
   );

   assign para_ready_o = ~hold_full_q && ~rst;
   assign accept       = para_valid_i && para_ready_o;
   assign frame_last   = (state_q == ST_SHIFT) && (div_cnt == DIV_LAST) && (bit_cnt_q == BIT_LAST);
   assign sh_rot       = MSB_FIRST ? {sh_q[WIDTH-2:0], sh_q[WIDTH-1]}
                                   : {sh_q[0], sh_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d = '0;
            if (accept) begin
               sh_d    = para_i;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sym_last) begin
               sh_d      = sh_rot;
               bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
            end
            if (frame_last) begin
               // A full rotation leaves sh_rot equal to the original word.
               if (hold_full_q) begin
                  sh_d        = hold_q;
                  hold_full_d = 1'b0;
               end else if (accept) begin
                  sh_d = para_i;
               end else begin
`ifdef PARA2SER_REPEAT_EN
                  state_d = ST_SHIFT;
`else
                  state_d = ST_IDLE;
`endif
               end
            end else if (accept) begin
               hold_d      = para_i;
               hold_full_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ser_o tracks the head of the next shift value so the first bit lands one cycle after accept.
   always_comb begin
      ser_d = 1'b0;
      if (state_d == ST_SHIFT) begin
         ser_d = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sh_q        <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         ser_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         ser_q       <= ser_d;
      end
   end

   assign ser_o        = ser_q;
   assign ser_valid_o  = (state_q == ST_SHIFT);
   assign sym_stb_o    = sym_stb;
   assign frame_done_o = frame_last;

endmodule

// File: tb/tb_para2ser_hs.sv
// Directed bench for para2ser_hs: an MSB-first and an LSB-first instance, WIDTH=8, DIV=4.
// Build with PARA2SER_REPEAT_EN to exercise the continuous-repeat variant instead.
module tb_para2ser_hs;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] para_a, para_b;
   logic         valid_a, valid_b;
   logic         ready_a, ser_a, sv_a, stb_a, done_a;
   logic         ready_b, ser_b, sv_b, stb_b, done_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   para2ser_hs #(.WIDTH(W), .DIV(D), .MSB_FIRST(1'b1)) u_msb (
      .clk          (clk),
      .rst          (rst),
      .para_i       (para_a),
      .para_valid_i (valid_a),
      .para_ready_o (ready_a),
      .ser_o        (ser_a),
      .ser_valid_o  (sv_a),
      .sym_stb_o    (stb_a),
      .frame_done_o (done_a)
   );

   para2ser_hs #(.WIDTH(W), .DIV(D), .MSB_FIRST(1'b0)) u_lsb (
      .clk          (clk),
      .rst          (rst),
      .para_i       (para_b),
      .para_valid_i (valid_b),
      .para_ready_o (ready_b),
      .ser_o        (ser_b),
      .ser_valid_o  (sv_b),
      .sym_stb_o    (stb_b),
      .frame_done_o (done_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input bit sel_b, input string tag, input logic e_ser,
                            input logic e_val, input logic e_stb, input logic e_done);
      if (sel_b) begin
         check_eq({tag, ".ser"},   {31'd0, ser_b},  {31'd0, e_ser});
         check_eq({tag, ".valid"}, {31'd0, sv_b},   {31'd0, e_val});
         check_eq({tag, ".stb"},   {31'd0, stb_b},  {31'd0, e_stb});
         check_eq({tag, ".done"},  {31'd0, done_b}, {31'd0, e_done});
      end else begin
         check_eq({tag, ".ser"},   {31'd0, ser_a},  {31'd0, e_ser});
         check_eq({tag, ".valid"}, {31'd0, sv_a},   {31'd0, e_val});
         check_eq({tag, ".stb"},   {31'd0, stb_a},  {31'd0, e_stb});
         check_eq({tag, ".done"},  {31'd0, done_a}, {31'd0, e_done});
      end
   endtask

   // Caller raises valid with the first word just before calling; the first
   // negedge here is the cycle after the accept edge.
   task automatic run_frames(input bit sel_b, input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input int nw, input bit msb_first, input string tag);
      logic [W-1:0] word_v;
      int           bitpos;
      int           n_stb;
      logic         e_ready;
      n_stb = 0;
      for (int c = 0; c < nw * W * D; c++) begin
         @(negedge clk);
         word_v  = (c < W * D) ? w0 : w1;
         bitpos  = (c % (W * D)) / D;
         e_ready = !(nw == 2 && c >= 1 && c < W * D);
         check_out(sel_b, tag, msb_first ? word_v[W-1-bitpos] : word_v[bitpos], 1'b1,
                   (c % D) == 0, (c % (W * D)) == (W * D - 1));
         check_eq({tag, ".ready"}, {31'd0, sel_b ? ready_b : ready_a}, {31'd0, e_ready});
         if (sel_b ? stb_b : stb_a) n_stb++;
         if (c == 0) begin
            if (nw == 2) begin
               if (sel_b) para_b = w1; else para_a = w1;
            end else begin
               // Scribble the bus: the word was already captured at accept.
               if (sel_b) begin valid_b = 1'b0; para_b = 8'hFF; end
               else       begin valid_a = 1'b0; para_a = 8'hFF; end
            end
         end else if (c == 1) begin
            if (sel_b) valid_b = 1'b0; else valid_a = 1'b0;
         end
         if ((c % (W * D)) == (W * D - 1))
            $display("%s: frame %0d word %02h sent", tag, c / (W * D), word_v);
      end
      check_eq({tag, ".stb_count"}, n_stb, nw * W);
      @(negedge clk);
      check_out(sel_b, {tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic run_midframe_reset();
      para_a  = 8'hA5;
      valid_a = 1'b1;
      @(negedge clk);
      para_a = 8'h3C;
      @(negedge clk);
      valid_a = 1'b0;
      check_eq("rst_mid.hold_full", {31'd0, ready_a}, 32'd0);
      for (int c = 2; c <= 13; c++) @(negedge clk);
      check_eq("rst_mid.running", {31'd0, sv_a}, 32'd1);
      rst = 1'b1;
      #1;
      check_out(1'b0, "rst_mid.async", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_mid.ready", {31'd0, ready_a}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         check_out(1'b0, "rst_mid.after", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check_eq("rst_mid.ready_after", {31'd0, ready_a}, 32'd1);
      $display("rst_mid: reset during bit 3, held word discarded");
   endtask

   task automatic run_repeat();
      logic [W-1:0] word_v;
      word_v  = 8'hF0;
      para_a  = word_v;
      valid_a = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         check_out(1'b0, "repeat", word_v[W-1-((c % (W * D)) / D)], 1'b1,
                   (c % D) == 0, (c % (W * D)) == (W * D - 1));
         if (c == 0) begin valid_a = 1'b0; para_a = 8'h00; end
         if ((c % (W * D)) == (W * D - 1)) $display("repeat: frame %0d of F0 sent", c / (W * D));
      end
   endtask

   initial begin
      rst     = 1'b1;
      para_a  = '0;
      para_b  = '0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      repeat (3) @(negedge clk);
      check_out(1'b0, "reset_hi", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset_hi.ready", {31'd0, ready_a}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_out(1'b0, "reset_rel", 1'b0, 1'b0, 1'b0, 1'b0);
      check_out(1'b1, "reset_rel_b", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset_rel.ready", {31'd0, ready_a}, 32'd1);
      check_eq("reset_rel_b.ready", {31'd0, ready_b}, 32'd1);
      $display("reset: released, both instances idle");

`ifdef PARA2SER_REPEAT_EN
      run_repeat();
`else
      para_a  = 8'hA5;
      valid_a = 1'b1;
      run_frames(1'b0, 8'hA5, 8'h00, 1, 1'b1, "single_msb");

      para_a  = 8'hA5;
      valid_a = 1'b1;
      run_frames(1'b0, 8'hA5, 8'h3C, 2, 1'b1, "b2b_msb");

      para_b  = 8'h01;
      valid_b = 1'b1;
      run_frames(1'b1, 8'h01, 8'h00, 1, 1'b0, "single_lsb");

      para_b  = 8'hA5;
      valid_b = 1'b1;
      run_frames(1'b1, 8'hA5, 8'h00, 1, 1'b0, "a5_lsb");

      run_midframe_reset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
